// File: rtl/mult_shift_add.sv
// Sequential unsigned shift-add multiplier: one partial product per clock,
// registered 2*WIDTH-bit product and a one-cycle done pulse on completion.
//
// state | meaning
// IDLE  | waiting for Load
// RUN   | iterating, one partial product per edge
// DONE  | new product presented for one cycle
module mult_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH:0]    acc;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     cnt;
    logic [WIDTH:0]    sum;
    logic [2*WIDTH:0]  shifted;
    logic              last_iter;

    // acc's top bit is always clear after a shift, so the add cannot overflow WIDTH+1 bits
    assign sum       = acc + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    assign shifted   = {sum, mplier} >> 1;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (Load) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     state_nxt = last_iter ? DONE : RUN;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (Load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= shifted[2*WIDTH:WIDTH];
            mplier <= shifted[WIDTH-1:0];
            cnt    <= cnt + CW'(1);
            if (last_iter) begin
                product <= shifted[2*WIDTH-1:0];
            end
        end
    end

endmodule
